rx_lane_arbiter: RTL and testbench

//  Collects the four byte lanes delivered by the PHY receiver (data_out_N/valid_out_N)
//  and serialises them onto a single byte stream for the downstream consumer.

---
 rtl/rx_lane_arbiter_if.sv | 23 ++
 rtl/rx_lane_arbiter.sv | 125 ++++++++++++
 tb/tb_rx_lane_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rx_lane_arbiter_if.sv
// Output byte stream of the lane arbiter: data, source lane and valid/ready handshake.
interface rx_lane_arbiter_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] data_out;
  logic [1:0]        lane_id_out;
  logic              valid_out;
  logic              ready_out;

  modport master (
    output data_out,
    output lane_id_out,
    output valid_out,
    input  ready_out
  );

  modport slave (
    input  data_out,
    input  lane_id_out,
    input  valid_out,
    output ready_out
  );
endinterface

// File: rtl/rx_lane_arbiter.sv
// Four-lane receive arbiter: per-lane FIFOs, round-robin grant onto one registered byte stream.
module rx_lane_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_f,
  input  logic              rst_L,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              valid_in_0,
  input  logic              valid_in_1,
  input  logic              valid_in_2,
  input  logic              valid_in_3,
  input  logic [3:0]        lane_en,
  rx_lane_arbiter_if.master out_bus,
  output logic [3:0]        fifo_full,
  output logic [3:0]        overflow,
  output logic              idle_out
);

  localparam int unsigned NL = 4;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] din [NL];
  logic [NL-1:0]     vin;
  logic [DATA_W-1:0] mem [NL][FIFO_DEPTH];
  logic [PW-1:0]     wptr [NL];
  logic [PW-1:0]     rptr [NL];
  logic [NL-1:0]     empty;
  logic [NL-1:0]     full;
  logic [NL-1:0]     push;
  logic [NL-1:0]     drop;
  logic [1:0]        rr_ptr;
  logic [1:0]        gnt;
  logic              found;
  logic              load;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        lane_q;
  logic              valid_q;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;
  assign vin    = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};

  // Per-lane occupancy flags and write qualification; a full lane never accepts, even when popped.
  always_comb begin
    for (int n = 0; n < NL; n++) begin
      empty[n] = (wptr[n] == rptr[n]);
      full[n]  = (wptr[n][AW-1:0] == rptr[n][AW-1:0]) && (wptr[n][AW] != rptr[n][AW]);
      push[n]  = vin[n] && lane_en[n] && !full[n];
      drop[n]  = vin[n] && lane_en[n] && full[n];
    end
  end

  // Round-robin search over non-empty lanes starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    gnt   = 2'd0;
    for (int k = 0; k < NL; k++) begin
      logic [1:0] idx;
      idx = rr_ptr + 2'(k);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign load = !valid_q || out_bus.ready_out;

  // Lane storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk_f) begin
    for (int n = 0; n < NL; n++) begin
      if (push[n]) mem[n][wptr[n][AW-1:0]] <= din[n];
    end
  end

  // FIFO pointers and sticky overflow flags.
  always_ff @(posedge clk_f or negedge rst_L) begin
    if (!rst_L) begin
      for (int n = 0; n < NL; n++) begin
        wptr[n] <= '0;
        rptr[n] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int n = 0; n < NL; n++) begin
        if (push[n]) wptr[n] <= wptr[n] + PW'(1);
        if (load && found && (gnt == 2'(n))) rptr[n] <= rptr[n] + PW'(1);
        if (drop[n]) overflow[n] <= 1'b1;
      end
    end
  end

  // Output slot: reload whenever empty or being consumed; hold under backpressure.
  always_ff @(posedge clk_f or negedge rst_L) begin
    if (!rst_L) begin
      data_q  <= '0;
      lane_q  <= 2'd0;
      valid_q <= 1'b0;
      rr_ptr  <= 2'd0;
    end else if (load) begin
      if (found) begin
        data_q  <= mem[gnt][rptr[gnt][AW-1:0]];
        lane_q  <= gnt;
        valid_q <= 1'b1;
        rr_ptr  <= gnt + 2'd1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_bus.data_out    = data_q;
  assign out_bus.lane_id_out = lane_q;
  assign out_bus.valid_out   = valid_q;
  assign fifo_full           = full;
  assign idle_out            = (&empty) && !valid_q;

endmodule

// File: tb/tb_rx_lane_arbiter.sv
// Scoreboard bench for rx_lane_arbiter: expected bytes queued at drive time, checked at transfer.
module tb_rx_lane_arbiter;

  logic       clk_f = 1'b0;
  logic       rst_L;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic [3:0] lane_en;
  logic       ready;
  logic [3:0] fifo_full;
  logic [3:0] overflow;
  logic       idle_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] sb [$];

  rx_lane_arbiter_if #(.DATA_W(8)) bus ();
  assign bus.ready_out = ready;

  rx_lane_arbiter #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk_f      (clk_f),
    .rst_L      (rst_L),
    .data_in_0  (din[0]),
    .data_in_1  (din[1]),
    .data_in_2  (din[2]),
    .data_in_3  (din[3]),
    .valid_in_0 (vin[0]),
    .valid_in_1 (vin[1]),
    .valid_in_2 (vin[2]),
    .valid_in_3 (vin[3]),
    .lane_en    (lane_en),
    .out_bus    (bus.master),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .idle_out   (idle_out)
  );

  always #5 clk_f = ~clk_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of lane inputs; valids drop after the capturing edge.
  task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    vin = v;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    @(posedge clk_f); #1;
    vin = 4'b0000;
  endtask

  task automatic expect_byte(input logic [1:0] lane, input logic [7:0] data);
    sb.push_back({lane, data});
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (!(idle_out && sb.size() == 0) && cyc < 60) begin
      @(posedge clk_f); #1;
      cyc++;
    end
    if (cyc >= 60) check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  // Transfer monitor: sampled on the falling edge, a transfer happens at the next rising edge.
  always @(negedge clk_f) begin
    if (rst_L && bus.valid_out && ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {22'd0, bus.lane_id_out, bus.data_out}, 32'h3ff);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("out_data", 32'(bus.data_out), 32'(e[7:0]));
        check("out_lane", 32'(bus.lane_id_out), 32'(e[9:8]));
      end
    end
  end

  initial begin
    rst_L   = 1'b0;
    vin     = 4'b0000;
    din[0] = 8'h00; din[1] = 8'h00; din[2] = 8'h00; din[3] = 8'h00;
    lane_en = 4'b1111;
    ready   = 1'b1;
    repeat (3) @(posedge clk_f);
    #1;
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd1);
    rst_L = 1'b1;

    // Reset mid-stream: buffered bytes vanish, outputs return to reset values immediately.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'b0001, 8'hE0 + 8'(i), 8'h00, 8'h00, 8'h00);
    check("pre_rst_valid", 32'(bus.valid_out), 32'd1);
    #2 rst_L = 1'b0;
    #1;
    check("arst_valid", 32'(bus.valid_out), 32'd0);
    check("arst_data", 32'(bus.data_out), 32'd0);
    check("arst_lane", 32'(bus.lane_id_out), 32'd0);
    check("arst_full", 32'(fifo_full), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_idle", 32'(idle_out), 32'd1);
    sb.delete();
    @(posedge clk_f); #1;
    rst_L = 1'b1;
    ready = 1'b1;
    repeat (5) @(posedge clk_f);
    #1;
    check("post_rst_valid", 32'(bus.valid_out), 32'd0);
    check("post_rst_idle", 32'(idle_out), 32'd1);

    // Single lane 2 stream with two-edge latency.
    expect_byte(2'd2, 8'hA1);
    expect_byte(2'd2, 8'hA2);
    expect_byte(2'd2, 8'hA3);
    drive(4'b0100, 8'h00, 8'h00, 8'hA1, 8'h00);
    check("lat_e0_valid", 32'(bus.valid_out), 32'd0);
    drive(4'b0100, 8'h00, 8'h00, 8'hA2, 8'h00);
    check("lat_e1_valid", 32'(bus.valid_out), 32'd1);
    check("lat_e1_data", 32'(bus.data_out), 32'hA1);
    check("lat_e1_lane", 32'(bus.lane_id_out), 32'd2);
    drive(4'b0100, 8'h00, 8'h00, 8'hA3, 8'h00);
    wait_idle("single");
    check("single_idle", 32'(idle_out), 32'd1);

    // Fairness: a lane 0 grant leaves the rr pointer at lane 1, then all lanes push together.
    expect_byte(2'd0, 8'h0F);
    drive(4'b0001, 8'h0F, 8'h00, 8'h00, 8'h00);
    wait_idle("rr_setup");
    expect_byte(2'd1, 8'h11);
    expect_byte(2'd2, 8'h12);
    expect_byte(2'd3, 8'h13);
    expect_byte(2'd0, 8'h10);
    drive(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
    wait_idle("fair");

    // Backpressure on lane 0: fills after five bytes, sixth dropped.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_byte(2'd0, 8'(i));
    for (int i = 0; i < 6; i++) begin
      drive(4'b0001, 8'(i), 8'h00, 8'h00, 8'h00);
      if (i == 3) check("bp_full_4", 32'(fifo_full[0]), 32'd0);
      if (i == 4) check("bp_full_5", 32'(fifo_full[0]), 32'd1);
    end
    check("bp_ovf", 32'(overflow), 32'b0001);
    repeat (4) @(posedge clk_f);
    #1;
    check("bp_hold_data", 32'(bus.data_out), 32'h00);
    check("bp_hold_valid", 32'(bus.valid_out), 32'd1);
    ready = 1'b1;
    wait_idle("bp");
    check("bp_ovf_sticky", 32'(overflow[0]), 32'd1);

    // Enable gating: disabled lane ignores input, already-buffered bytes still drain.
    ready = 1'b0;
    expect_byte(2'd1, 8'h50);
    expect_byte(2'd1, 8'h51);
    drive(4'b0010, 8'h00, 8'h50, 8'h00, 8'h00);
    drive(4'b0010, 8'h00, 8'h51, 8'h00, 8'h00);
    lane_en = 4'b1101;
    drive(4'b0010, 8'h00, 8'h55, 8'h00, 8'h00);
    check("en_ovf1", 32'(overflow[1]), 32'd0);
    ready = 1'b1;
    wait_idle("en");
    lane_en = 4'b1111;

    // Full lane 3 popped and pushed in the same cycle: push is dropped.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_byte(2'd3, 8'h30 + 8'(i));
      drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h30 + 8'(i));
    end
    check("fp_full3", 32'(fifo_full[3]), 32'd1);
    check("fp_ovf3_pre", 32'(overflow[3]), 32'd0);
    ready = 1'b1;
    drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h35);
    check("fp_ovf3", 32'(overflow[3]), 32'd1);
    check("fp_full3_after", 32'(fifo_full[3]), 32'd0);
    wait_idle("fp");
    check("final_ovf", 32'(overflow), 32'b1001);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
